// File: rtl/lsu_pkg.sv
// Shared encodings and load-data formatting for the OBI load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_X = 2'd3
    } lsu_size_e;

    // Pending-FIFO entry layout, LSB first: tag, off, unsigned, size, we.
    localparam int unsigned LSU_OFF_W  = 2;
    localparam int unsigned LSU_SIZE_W_BITS = 2;
    localparam int unsigned LSU_ENTRY_FIXED_W = 1 + LSU_SIZE_W_BITS + 1 + LSU_OFF_W;

    function automatic logic [31:0] lsu_load_format(
        input logic [31:0] rdata,
        input logic [1:0]  off,
        input lsu_size_e   size,
        input logic        uns
    );
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (size)
            LSU_SIZE_B: return {{24{~uns & lane[7]}}, lane[7:0]};
            LSU_SIZE_H: return {{16{~uns & lane[15]}}, lane[15:0]};
            default:    return rdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_pending_fifo.sv
// In-order FIFO of outstanding bus transactions; circular pointers plus count.
module lsu_pending_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i & ~empty_o;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/lsu_obi.sv
// Load/store unit between EXEC and the OBI data port: pipelined issue,
// lane alignment, misaligned-access trapping and the end-of-test watch word.
module lsu_obi
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADR_PMEM_START  = 32'h0000_2600,
    parameter logic [31:0] ADR_DMEM_START  = 32'h0000_2800,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TAG_W           = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             rsp_we,
    output logic             in_range_peripheral,
    output logic             idle,
    output logic [31:0]      final_value,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic [31:0]      data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_wdata_o,
    input  logic [31:0]      data_rdata_i,
    input  logic             data_rvalid_i
);
    localparam int unsigned FW = LSU_ENTRY_FIXED_W + TAG_W;

    lsu_size_e        size;
    logic [1:0]       off;
    logic             misaligned, mis_accept, watch_hit;
    logic [3:0]       be;
    logic [31:0]      wdata_rep, wdata_sh, lane_mask;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]    fifo_head;
    logic             err_pend_q, err_we_q;
    logic [TAG_W-1:0] err_tag_q;
    logic [31:0]      final_value_q;

    assign size = lsu_size_e'(req_size);
    assign off  = req_addr[1:0];

    always_comb begin
        case (size)
            LSU_SIZE_B: misaligned = 1'b0;
            LSU_SIZE_H: misaligned = off[0];
            LSU_SIZE_W: misaligned = (off != 2'b00);
            default:    misaligned = 1'b1;
        endcase
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
        if (req_we) begin
            case (size)
                LSU_SIZE_B: begin be = 4'b0001 << off; wdata_rep = {4{req_wdata[7:0]}}; end
                LSU_SIZE_H: begin be = 4'b0011 << off; wdata_rep = {2{req_wdata[15:0]}}; end
                LSU_SIZE_W: be = 4'b1111;
                default:    be = 4'b0000;
            endcase
        end
    end

    assign wdata_sh  = wdata_rep << {off, 3'b000};
    assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign data_req_o   = req_valid & ~misaligned & ~fifo_full;
    assign data_addr_o  = req_valid ? {req_addr[31:2], 2'b00} : '0;
    assign data_we_o    = req_valid & req_we;
    assign data_be_o    = req_valid ? be : '0;
    assign data_wdata_o = (req_valid & req_we) ? (wdata_sh & lane_mask) : '0;

    // Misaligned accesses bypass the bus, so they wait until nothing is in flight
    // to keep responses in order and off the rvalid cycle.
    assign mis_accept = req_valid & misaligned & fifo_empty & ~err_pend_q;
    assign fifo_push  = data_req_o & data_gnt_i;
    assign req_ready  = fifo_push | mis_accept;
    assign fifo_pop   = data_rvalid_i & ~fifo_empty;

    lsu_pending_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (FW)
    ) u_pending (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i ({req_we, req_size, req_unsigned, off, req_tag}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_pend_q <= 1'b0;
            err_we_q   <= 1'b0;
            err_tag_q  <= '0;
        end else begin
            err_pend_q <= mis_accept;
            if (mis_accept) begin
                err_we_q  <= req_we;
                err_tag_q <= req_tag;
            end
        end
    end

    always_comb begin
        rsp_valid = err_pend_q | fifo_pop;
        rsp_err   = err_pend_q;
        rsp_we    = err_pend_q ? err_we_q : fifo_head[FW-1];
        rsp_tag   = err_pend_q ? err_tag_q : fifo_head[TAG_W-1:0];
        rsp_rdata = '0;
        if (fifo_pop && !err_pend_q && !fifo_head[FW-1])
            rsp_rdata = lsu_load_format(data_rdata_i, fifo_head[TAG_W+1:TAG_W],
                                        lsu_size_e'(fifo_head[TAG_W+4:TAG_W+3]),
                                        fifo_head[TAG_W+2]);
    end

    assign in_range_peripheral = (req_addr >= ADR_PMEM_START) && (req_addr < ADR_DMEM_START);
    assign idle = fifo_empty & ~err_pend_q & ~req_valid;

    assign watch_hit = fifo_push & data_we_o & (req_addr[31:2] == ADR_PMEM_START[31:2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            final_value_q <= '0;
        end else if (watch_hit) begin
            for (int unsigned i = 0; i < 4; i++)
                if (data_be_o[i]) final_value_q[8*i +: 8] <= data_wdata_o[8*i +: 8];
        end
    end

    assign final_value = final_value_q;

endmodule

// File: tb/tb_lsu_obi.sv
// Directed bench for lsu_obi: per-access vector table plus pipelining and reset sequences.
module tb_lsu_obi;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_err, rsp_we;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_tag;
    logic        in_range_peripheral, idle;
    logic [31:0] final_value;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_obi #(
        .ADR_PMEM_START  (32'h0000_2600),
        .ADR_DMEM_START  (32'h0000_2800),
        .MAX_OUTSTANDING (2),
        .TAG_W           (5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_we              (req_we),
        .req_size            (req_size),
        .req_unsigned        (req_unsigned),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_tag             (req_tag),
        .rsp_valid           (rsp_valid),
        .rsp_rdata           (rsp_rdata),
        .rsp_tag             (rsp_tag),
        .rsp_err             (rsp_err),
        .rsp_we              (rsp_we),
        .in_range_peripheral (in_range_peripheral),
        .idle                (idle),
        .final_value         (final_value),
        .data_req_o          (data_req_o),
        .data_gnt_i          (data_gnt_i),
        .data_addr_o         (data_addr_o),
        .data_we_o           (data_we_o),
        .data_be_o           (data_be_o),
        .data_wdata_o        (data_wdata_o),
        .data_rdata_i        (data_rdata_i),
        .data_rvalid_i       (data_rvalid_i)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic [31:0] rdata;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_per;
        logic [31:0] exp_rsp;
        logic        exp_err;
        logic [31:0] exp_fv;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd, input logic [4:0] t);
        req_valid = v; req_we = we; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd; req_tag = t;
    endtask

    initial begin
        reset = 1'b1;
        drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;

        //        we  sz  u  addr          wdata         tag  rdata       req be      exp_wdata     per rsp           err fv
        vecs[0]  = '{0, 2, 0, 32'h0000_2800, 32'h0,        3,  32'hDEADBEEF, 1, 4'hF, 32'h0,        0, 32'hDEADBEEF, 0, 32'h0};
        vecs[1]  = '{1, 0, 0, 32'h0000_2603, 32'h0000_00A5, 4,  32'h12345678, 1, 4'h8, 32'hA500_0000, 1, 32'h0,        0, 32'hA500_0000};
        vecs[2]  = '{0, 0, 0, 32'h0000_2801, 32'h0,        5,  32'h0000_8000, 1, 4'hF, 32'h0,        0, 32'hFFFF_FF80, 0, 32'hA500_0000};
        vecs[3]  = '{0, 0, 1, 32'h0000_2801, 32'h0,        6,  32'h0000_8000, 1, 4'hF, 32'h0,        0, 32'h0000_0080, 0, 32'hA500_0000};
        vecs[4]  = '{0, 1, 0, 32'h0000_2801, 32'h0,        7,  32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        1, 32'hA500_0000};
        vecs[5]  = '{1, 1, 0, 32'h0000_2602, 32'h1234_BEEF, 8,  32'h0,        1, 4'hC, 32'hBEEF_0000, 1, 32'h0,        0, 32'hBEEF_0000};
        vecs[6]  = '{0, 1, 1, 32'h0000_2802, 32'h0,        9,  32'h8001_7FFF, 1, 4'hF, 32'h0,        0, 32'h0000_8001, 0, 32'hBEEF_0000};
        vecs[7]  = '{0, 1, 0, 32'h0000_2802, 32'h0,        10, 32'h8001_7FFF, 1, 4'hF, 32'h0,        0, 32'hFFFF_8001, 0, 32'hBEEF_0000};
        vecs[8]  = '{1, 2, 0, 32'h0000_2601, 32'hFFFF_FFFF, 11, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        1, 32'hBEEF_0000};
        vecs[9]  = '{0, 3, 0, 32'h0000_2800, 32'h0,        12, 32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        1, 32'hBEEF_0000};
        vecs[10] = '{1, 0, 0, 32'h0000_2600, 32'hFFFF_FF11, 13, 32'h0,        1, 4'h1, 32'h0000_0011, 1, 32'h0,        0, 32'hBEEF_0011};
        vecs[11] = '{0, 0, 0, 32'h0000_3003, 32'h0,        14, 32'h7F00_0000, 1, 4'hF, 32'h0,        0, 32'h0000_007F, 0, 32'hBEEF_0011};
        vecs[12] = '{0, 0, 1, 32'h0000_27FF, 32'h0,        15, 32'hAB00_0000, 1, 4'hF, 32'h0,        1, 32'h0000_00AB, 0, 32'hBEEF_0011};
        vecs[13] = '{0, 0, 0, 32'h0000_25FF, 32'h0,        16, 32'h8012_3456, 1, 4'hF, 32'h0,        0, 32'hFFFF_FF80, 0, 32'hBEEF_0011};
        vecs[14] = '{1, 2, 0, 32'h0000_2604, 32'hCAFE_F00D, 17, 32'h0,        1, 4'hF, 32'hCAFE_F00D, 1, 32'h0,        0, 32'hBEEF_0011};
        vecs[15] = '{0, 1, 0, 32'h0000_2800, 32'h0,        18, 32'h0000_FFFE, 1, 4'hF, 32'h0,        0, 32'hFFFF_FFFE, 0, 32'hBEEF_0011};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data_req", 32'(data_req_o), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_final_value", final_value, 32'd0);
        next_cycle();

        // One access per vector: issue with same-cycle gnt, response next cycle
        for (int i = 0; i < 16; i++) begin
            drive_req(1'b1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
            data_gnt_i = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_data_req", i), 32'(data_req_o), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'd1);
            chk($sformatf("v%0d_periph", i), 32'(in_range_peripheral), 32'(vecs[i].exp_per));
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d_be", i), 32'(data_be_o), 32'(vecs[i].exp_be));
                chk($sformatf("v%0d_wdata", i), data_wdata_o, vecs[i].exp_wdata);
                chk($sformatf("v%0d_addr", i), data_addr_o, {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d_we", i), 32'(data_we_o), 32'(vecs[i].we));
            end
            next_cycle();
            req_valid = 1'b0; data_gnt_i = 1'b0;
            data_rvalid_i = vecs[i].exp_req;
            data_rdata_i = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rsp);
            chk($sformatf("v%0d_rsp_tag", i), 32'(rsp_tag), 32'(vecs[i].tag));
            chk($sformatf("v%0d_rsp_we", i), 32'(rsp_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_final_value", i), final_value, vecs[i].exp_fv);
            next_cycle();
            data_rvalid_i = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_rsp_gone", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d_idle", i), 32'(idle), 32'd1);
            next_cycle();
        end

        // Back-to-back loads with rvalid three cycles after the first gnt
        data_gnt_i = 1'b1;
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2800, 32'h0, 5'd1);
        @(negedge clk);
        chk("pipe_c0_ready", 32'(req_ready), 32'd1);
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2804, 32'h0, 5'd2);
        @(negedge clk);
        chk("pipe_c1_ready", 32'(req_ready), 32'd1);
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2808, 32'h0, 5'd3);
        @(negedge clk);
        chk("pipe_c2_full_req", 32'(data_req_o), 32'd0);
        chk("pipe_c2_full_ready", 32'(req_ready), 32'd0);
        next_cycle();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
        @(negedge clk);
        chk("pipe_c3_no_bypass", 32'(data_req_o), 32'd0);
        chk("pipe_c3_rsp_tag", 32'(rsp_tag), 32'd1);
        chk("pipe_c3_rsp_rdata", rsp_rdata, 32'h1111_1111);
        next_cycle();
        data_rdata_i = 32'h2222_2222;
        @(negedge clk);
        chk("pipe_c4_ready", 32'(req_ready), 32'd1);
        chk("pipe_c4_rsp_tag", 32'(rsp_tag), 32'd2);
        chk("pipe_c4_rsp_rdata", rsp_rdata, 32'h2222_2222);
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_280C, 32'h0, 5'd4);
        data_rdata_i = 32'h3333_3333;
        @(negedge clk);
        chk("pipe_c5_ready", 32'(req_ready), 32'd1);
        chk("pipe_c5_rsp_tag", 32'(rsp_tag), 32'd3);
        chk("pipe_c5_rsp_rdata", rsp_rdata, 32'h3333_3333);
        next_cycle();
        req_valid = 1'b0;
        data_rdata_i = 32'h4444_4444;
        @(negedge clk);
        chk("pipe_c6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pipe_c6_rsp_tag", 32'(rsp_tag), 32'd4);
        chk("pipe_c6_rsp_rdata", rsp_rdata, 32'h4444_4444);
        next_cycle();
        data_rvalid_i = 1'b0;
        @(negedge clk);
        chk("pipe_c7_idle", 32'(idle), 32'd1);
        chk("pipe_c7_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Misaligned access waits while a load is outstanding
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2800, 32'h0, 5'd5);
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2802, 32'h0, 5'd6);
        @(negedge clk);
        chk("mis_busy_ready", 32'(req_ready), 32'd0);
        chk("mis_busy_req", 32'(data_req_o), 32'd0);
        next_cycle();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555;
        @(negedge clk);
        chk("mis_busy_rsp_tag", 32'(rsp_tag), 32'd5);
        chk("mis_busy_still_wait", 32'(req_ready), 32'd0);
        next_cycle();
        data_rvalid_i = 1'b0;
        @(negedge clk);
        chk("mis_free_ready", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("mis_free_err", 32'(rsp_err), 32'd1);
        chk("mis_free_tag", 32'(rsp_tag), 32'd6);
        next_cycle();

        // Reset with two loads pending, then stray rvalids
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2800, 32'h0, 5'd20);
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2804, 32'h0, 5'd21);
        next_cycle();
        req_valid = 1'b0; data_gnt_i = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h6666_6666;
        @(negedge clk);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_idle", 32'(idle), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("rst_mid_rsp_valid2", 32'(rsp_valid), 32'd0);
        chk("rst_mid_final_value", final_value, 32'd0);
        next_cycle();
        data_rvalid_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
